// File: rtl/loader_pkg.sv
// Shared definitions for the UART memory loader: FSM state encoding and
// the segment tag bytes understood by the protocol.
package loader_pkg;

   typedef enum logic [2:0] {
      ST_RUN,
      ST_TAG,
      ST_LEN0,
      ST_LEN1,
      ST_WORD,
      ST_WRITE,
      ST_ERR
   } ld_state_t;

   localparam logic [7:0] TAG_INSTR = 8'h49;
   localparam logic [7:0] TAG_DATA  = 8'h44;
   localparam logic [7:0] TAG_END   = 8'h45;

endpackage

// File: rtl/uart_word_pack.sv
// Packs four received bytes into a little-endian 32-bit word; word_done
// flags the fourth byte so the word is complete on the following cycle.
module uart_word_pack (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_done
);

   logic [1:0] byte_cnt;

   // Shifting in from the top leaves the first byte in bits [7:0].
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt <= '0;
         word     <= '0;
      end else if (clr) begin
         byte_cnt <= '0;
      end else if (byte_valid) begin
         word     <= {byte_in, word[31:8]};
         byte_cnt <= byte_cnt + 2'd1;
      end
   end

   assign word_done = byte_valid && !clr && (byte_cnt == 2'd3);

endmodule

// File: rtl/mem_load_ctrl.sv
// UART boot loader: holds the CPU in reset while tagged segments received
// over the UART are written word by word into instruction or data memory.
//
//  state | meaning
//  RUN   | CPU running, CPU owns memories, waiting for start
//  TAG   | waiting for segment tag (I / D / E)
//  LEN0  | waiting for word-count low byte
//  LEN1  | waiting for word-count high byte, range check
//  WORD  | collecting four bytes of the next word
//  WRITE | one-cycle write strobe to the selected memory
//  ERR   | load aborted, waiting for start
module mem_load_ctrl
   import loader_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
   parameter int unsigned ADDR_W         = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              rx_valid,
   input  logic [7:0]        rx_byte,
   output logic              cpu_en,
   output logic              cpu_rst,
   output logic              mem_sel,
   output logic              ld_we_instr,
   output logic              ld_we_data,
   output logic [ADDR_W-1:0] ld_addr,
   output logic [31:0]       ld_wdata,
   output logic              busy,
   output logic              error
);

   localparam int unsigned      TMR_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [32:0]      N_MAX    = 33'd1 << ADDR_W;

   ld_state_t         state, state_nxt;
   logic              seg_data;
   logic [7:0]        len_lo;
   logic [15:0]       len_n;
   logic              len_bad;
   logic [15:0]       remain;
   logic [TMR_W-1:0]  tmr;
   logic              tmr_tc;
   logic              idle_state;
   logic              pack_clr;
   logic              pack_valid;
   logic              word_done;
   logic [ADDR_W-1:0] addr;

   assign len_n      = {rx_byte, len_lo};
   assign len_bad    = (len_n == 16'd0) || ({17'd0, len_n} > N_MAX);
   assign tmr_tc     = (tmr == '0);
   assign idle_state = (state == ST_TAG) || (state == ST_LEN0) ||
                       (state == ST_LEN1) || (state == ST_WORD);
   assign pack_clr   = (state == ST_LEN1) && rx_valid;
   assign pack_valid = (state == ST_WORD) && rx_valid;

   uart_word_pack u_pack (
      .clk       (clk),
      .rst       (rst),
      .clr       (pack_clr),
      .byte_valid(pack_valid),
      .byte_in   (rx_byte),
      .word      (ld_wdata),
      .word_done (word_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_RUN;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:   if (start) state_nxt = ST_TAG;
         ST_TAG: begin
            if (rx_valid) begin
               if (rx_byte == TAG_INSTR || rx_byte == TAG_DATA) state_nxt = ST_LEN0;
               else if (rx_byte == TAG_END)                     state_nxt = ST_RUN;
               else                                             state_nxt = ST_ERR;
            end else if (tmr_tc) begin
               state_nxt = ST_ERR;
            end
         end
         ST_LEN0: begin
            if (rx_valid)    state_nxt = ST_LEN1;
            else if (tmr_tc) state_nxt = ST_ERR;
         end
         ST_LEN1: begin
            if (rx_valid)    state_nxt = len_bad ? ST_ERR : ST_WORD;
            else if (tmr_tc) state_nxt = ST_ERR;
         end
         ST_WORD: begin
            if (word_done)               state_nxt = ST_WRITE;
            else if (!rx_valid && tmr_tc) state_nxt = ST_ERR;
         end
         ST_WRITE: state_nxt = (remain == 16'd1) ? ST_TAG : ST_WORD;
         ST_ERR:   if (start) state_nxt = ST_TAG;
         default:  state_nxt = ST_RUN;
      endcase
   end

   // Idle timer is a down-counter; WRITE freezes it since no byte is expected there.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_data <= 1'b0;
         len_lo   <= '0;
         remain   <= '0;
         addr     <= '0;
         tmr      <= '0;
      end else begin
         if (idle_state) begin
            if (rx_valid)     tmr <= TMR_LOAD;
            else if (!tmr_tc) tmr <= tmr - TMR_W'(1);
         end else if (state != ST_WRITE) begin
            tmr <= TMR_LOAD;
         end
         if (state == ST_TAG && rx_valid)  seg_data <= (rx_byte == TAG_DATA);
         if (state == ST_LEN0 && rx_valid) len_lo <= rx_byte;
         if (state == ST_LEN1 && rx_valid) begin
            remain <= len_n;
            addr   <= '0;
         end
         if (state == ST_WRITE) begin
            remain <= remain - 16'd1;
            addr   <= addr + ADDR_W'(1);
         end
      end
   end

   always_comb begin
      cpu_en      = (state == ST_RUN);
      cpu_rst     = (state != ST_RUN);
      mem_sel     = (state != ST_RUN);
      busy        = (state != ST_RUN);
      error       = (state == ST_ERR);
      ld_we_instr = (state == ST_WRITE) && !seg_data;
      ld_we_data  = (state == ST_WRITE) && seg_data;
   end

   assign ld_addr = addr;

endmodule
